// File: rtl/coin_feeder.sv
// Coin intake: per-sensor 2-flop synchroniser and debounce, coin FIFO, burst replay to the vending FSM.
// Build option: define COIN_FEEDER_STATS_EN to add the saturating 8-bit total_value output.
module coin_feeder #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT         = 16,
    parameter int DEPTH           = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    coin5_raw,
    input  logic                    coin10_raw,
    output logic [1:0]              coin_code,
    output logic                    busy,
    output logic                    reject,
`ifdef COIN_FEEDER_STATS_EN
    output logic [7:0]              total_value,
`endif
    output logic [$clog2(DEPTH):0]  pending
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int IW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] DB_MAX   = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] DB_ARM   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [IW-1:0] TO_MAX   = IW'(TIMEOUT);
    localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, COLLECT, BURST} state_t;

    logic [1:0]    sync5_q, sync10_q;
    logic [CW-1:0] cnt5_q, cnt5_d, cnt10_q, cnt10_d;
    logic          det5, det10;
    logic          full, push, pop, reject_d;
    logic [1:0]    push_code;
    logic [1:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   pending_q, pending_d, remain_q;
    logic [IW-1:0] idle_q;
    state_t        state_q;
    logic [1:0]    code_q;
    logic          busy_q, reject_q;

    // NOTE: every clocked block uses <= so all flops see pre-edge values, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync5_q  <= '0;
            sync10_q <= '0;
            cnt5_q   <= '0;
            cnt10_q  <= '0;
        end else begin
            sync5_q  <= {sync5_q[0], coin5_raw};
            sync10_q <= {sync10_q[0], coin10_raw};
            cnt5_q   <= cnt5_d;
            cnt10_q  <= cnt10_d;
        end
    end

    // NOTE: each always_comb output is defaulted first so no path can leave it unassigned (no latch).
    always_comb begin
        cnt5_d  = '0;
        cnt10_d = '0;
        if (sync5_q[1])
            cnt5_d = (cnt5_q == DB_MAX) ? cnt5_q : cnt5_q + CW'(1);
        if (sync10_q[1])
            cnt10_d = (cnt10_q == DB_MAX) ? cnt10_q : cnt10_q + CW'(1);
        // Detect is the step onto DB_MAX, so a held level yields exactly one detect.
        det5  = sync5_q[1]  && (cnt5_q  == DB_ARM);
        det10 = sync10_q[1] && (cnt10_q == DB_ARM);
    end

    always_comb begin
        full      = (pending_q == FULL_CNT);
        push      = (det5 ^ det10) && !full;
        reject_d  = (det5 && det10) || ((det5 ^ det10) && full);
        push_code = det10 ? 2'b10 : 2'b01;
        pop       = 1'b0;
        unique case (state_q)
            COLLECT: pop = (idle_q == TO_MAX) || full;
            BURST:   pop = (remain_q != '0);
            default: pop = 1'b0;
        endcase
        pending_d = pending_q + (PW+1)'(push) - (PW+1)'(pop);
    end

    // NOTE: FIFO storage has no reset; the pointers and pending count alone mark valid entries.
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= push_code;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            pending_q <= '0;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + PW'(1);
            pending_q <= pending_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idle_q   <= '0;
            remain_q <= '0;
            code_q   <= 2'b00;
            busy_q   <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            code_q   <= pop ? mem_q[rd_ptr_q] : 2'b00;
            reject_q <= reject_d;
            unique case (state_q)
                IDLE: begin
                    if (push) begin
                        state_q <= COLLECT;
                        idle_q  <= '0;
                    end
                end
                COLLECT: begin
                    if (pop) begin
                        // The entry pop is the first of pending_q; coins pushed now wait for the next burst.
                        state_q  <= BURST;
                        busy_q   <= 1'b1;
                        remain_q <= pending_q - (PW+1)'(1);
                    end else if (push) begin
                        idle_q <= '0;
                    end else if (idle_q != TO_MAX) begin
                        idle_q <= idle_q + IW'(1);
                    end
                end
                BURST: begin
                    if (pop) begin
                        remain_q <= remain_q - (PW+1)'(1);
                    end else begin
                        busy_q  <= 1'b0;
                        idle_q  <= '0;
                        state_q <= (pending_d != '0) ? COLLECT : IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef COIN_FEEDER_STATS_EN
    logic [7:0] total_q;
    logic [8:0] total_sum;

    // Code 01 is worth 1 and code 10 is worth 2, so the code itself is the increment.
    assign total_sum = {1'b0, total_q} + (pop ? {7'b0, mem_q[rd_ptr_q]} : 9'd0);

    always_ff @(posedge clk) begin
        if (rst)
            total_q <= '0;
        else
            total_q <= total_sum[8] ? 8'hFF : total_sum[7:0];
    end

    assign total_value = total_q;
`endif

    assign coin_code = code_q;
    assign busy      = busy_q;
    assign reject    = reject_q;
    assign pending   = pending_q;
endmodule

// File: tb/tb_coin_feeder.sv
// Scoreboard bench for coin_feeder: a queue-based reference model predicts emissions and rejects,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_coin_feeder;
    localparam int DB    = 4;
    localparam int TO    = 16;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst, coin5_raw, coin10_raw;
    logic [1:0] coin_code;
    logic       busy, reject;
    logic [2:0] pending;
`ifdef COIN_FEEDER_STATS_EN
    logic [7:0] total_value;
`endif

    always #5 clk = ~clk;

    coin_feeder #(.DEBOUNCE_CYCLES(DB), .TIMEOUT(TO), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .coin5_raw  (coin5_raw),
        .coin10_raw (coin10_raw),
        .coin_code  (coin_code),
        .busy       (busy),
        .reject     (reject),
`ifdef COIN_FEEDER_STATS_EN
        .total_value(total_value),
`endif
        .pending    (pending)
    );

    typedef struct {
        int         cyc;
        logic [1:0] code;
    } exp_t;

    exp_t       code_sb[$];
    int         rej_sb[$];
    logic [1:0] fifo[$];

    int   checks = 0, errors = 0;
    int   cyc = 0;
    bit   mon_en = 0;
    int   n_codes = 0, n_rejects = 0;
    int   last_code_cyc = -1, last_rej_cyc = -1;

    logic [1:0] h5 = '0, h10 = '0;
    int   run5 = 0, run10 = 0;
    bit   bursting = 0;
    int   burst_left = 0;
    int   anchor = 0;
    bit   m_busy = 0;
    int   m_total = 0;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, got, exp);
        end
    endtask

    // Reference model for one rising edge, from the behavioural rules: raw levels reach the
    // debouncer two edges late, a coin is detected when its high run length hits DB, bursts
    // replay the whole queue once TO idle cycles have passed since the anchor or the queue is full.
    task automatic model_step(input logic c5, input logic c10, input logic r);
        logic s5, s10;
        bit d5, d10, full, pushv, popv, end_burst;
        logic [1:0] pc;
        if (r) begin
            h5 = '0; h10 = '0; run5 = 0; run10 = 0;
            fifo.delete();
            bursting = 0; burst_left = 0; m_busy = 0; m_total = 0;
            return;
        end
        s5  = h5[1];  h5  = {h5[0], c5};
        s10 = h10[1]; h10 = {h10[0], c10};
        run5  = s5  ? run5 + 1  : 0;
        run10 = s10 ? run10 + 1 : 0;
        d5  = (run5 == DB);
        d10 = (run10 == DB);
        full  = (fifo.size() == DEPTH);
        pushv = (d5 != d10) && !full;
        if ((d5 && d10) || ((d5 != d10) && full))
            rej_sb.push_back(cyc);
        popv = 0;
        end_burst = 0;
        if (bursting) begin
            if (burst_left > 0) begin
                popv = 1;
                burst_left--;
            end else begin
                bursting  = 0;
                end_burst = 1;
            end
        end else if (fifo.size() > 0 && ((cyc - 1 - anchor) >= TO || full)) begin
            bursting   = 1;
            burst_left = fifo.size() - 1;
            popv       = 1;
        end
        m_busy = popv;
        if (popv) begin
            pc = fifo.pop_front();
            code_sb.push_back('{cyc, pc});
            m_total = (m_total + int'(pc) > 255) ? 255 : m_total + int'(pc);
        end
        if (pushv) begin
            fifo.push_back(d10 ? 2'b10 : 2'b01);
            if (!bursting)
                anchor = cyc;
        end
        if (end_burst)
            anchor = cyc;
    endtask

    task automatic step(input logic c5, input logic c10, input logic r);
        coin5_raw  = c5;
        coin10_raw = c10;
        rst        = r;
        @(posedge clk);
        cyc++;
        model_step(c5, c10, r);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        int   rc;
        if (mon_en) begin
            if (coin_code != 2'b00) begin
                n_codes++;
                last_code_cyc = cyc;
                if (code_sb.size() == 0) begin
                    check("code_unexpected", int'(coin_code), 0);
                end else begin
                    e = code_sb.pop_front();
                    check("code_value", int'(coin_code), int'(e.code));
                    check("code_cycle", cyc, e.cyc);
                end
            end else if (code_sb.size() > 0 && code_sb[0].cyc <= cyc) begin
                e = code_sb.pop_front();
                check("code_missed", int'(coin_code), int'(e.code));
            end
            if (reject) begin
                n_rejects++;
                last_rej_cyc = cyc;
                if (rej_sb.size() == 0) begin
                    check("reject_unexpected", int'(reject), 0);
                end else begin
                    rc = rej_sb.pop_front();
                    check("reject_cycle", cyc, rc);
                end
            end else if (rej_sb.size() > 0 && rej_sb[0] <= cyc) begin
                rc = rej_sb.pop_front();
                check("reject_missed", int'(reject), 1);
            end
            check("pending", int'(pending), fifo.size());
            check("busy", int'(busy), int'(m_busy));
`ifdef COIN_FEEDER_STATS_EN
            check("total_value", int'(total_value), m_total);
`endif
        end
    end

    initial begin
        int t0, base_codes, base_rej;
        int kind, hold, gap;
        bit ch;

        step(1'b0, 1'b0, 1'b1);
        mon_en = 1;
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        check("reset_coin_code", int'(coin_code), 0);
        check("reset_pending", int'(pending), 0);
        idle(5);

        // Single 5-coin held 8 cycles: one 01 at relative cycle 23.
        t0 = cyc; base_codes = n_codes;
        for (int r = 0; r < 40; r++)
            step(r < 8, 1'b0, 1'b0);
        check("single_code_cycle", last_code_cyc - t0, 23);
        check("single_code_count", n_codes - base_codes, 1);

        // Two-coin burst: 10 then 5, last push at 16, codes at 33 and 34.
        t0 = cyc; base_codes = n_codes;
        for (int r = 0; r < 45; r++)
            step(r >= 10 && r < 16, r < 6, 1'b0);
        check("two_coin_last_cycle", last_code_cyc - t0, 34);
        check("two_coin_count", n_codes - base_codes, 2);

        // Bounce: two 3-cycle highs on the 10 line never reach the debounce count.
        t0 = cyc; base_codes = n_codes; base_rej = n_rejects;
        for (int r = 0; r < 30; r++)
            step(1'b0, (r < 3) || (r >= 4 && r < 7), 1'b0);
        check("bounce_codes", n_codes - base_codes, 0);
        check("bounce_rejects", n_rejects - base_rej, 0);

        // Simultaneous rise on both lines: reject at cycle 6, nothing queued.
        t0 = cyc; base_codes = n_codes;
        for (int r = 0; r < 30; r++)
            step(r < 6, r < 6, 1'b0);
        check("simul_reject_cycle", last_rej_cyc - t0, 6);
        check("simul_codes", n_codes - base_codes, 0);

        // Overflow: pushes at 6, 13, 20, 27 fill the queue; fifth detect at 28 is rejected.
        t0 = cyc; base_codes = n_codes;
        for (int r = 0; r < 60; r++)
            step((r < 6) || (r >= 14 && r < 20) || (r >= 22 && r < 28),
                 (r >= 7 && r < 13) || (r >= 21 && r < 27), 1'b0);
        check("overflow_reject_cycle", last_rej_cyc - t0, 28);
        check("overflow_code_count", n_codes - base_codes, 4);

        // Reset during the second code of a 3-coin burst (codes due at 37, 38, 39), then a fresh coin.
        t0 = cyc; base_codes = n_codes;
        for (int r = 0; r < 80; r++)
            step((r < 6) || (r >= 14 && r < 20) || (r >= 45 && r < 53),
                 (r >= 7 && r < 13), r == 38);
        check("rst_burst_codes", n_codes - base_codes, 3);
        check("rst_fresh_code_cycle", last_code_cyc - t0, 68);

        // Randomised segments: clean coins, bounces, simultaneous presses, occasional reset.
        for (int s = 0; s < 400; s++) begin
            kind = $urandom_range(0, 19);
            ch   = 1'($urandom_range(0, 1));
            if (kind == 0) begin
                step(1'b0, 1'b0, 1'b1);
            end else if (kind <= 2) begin
                hold = $urandom_range(1, DB - 1);
                for (int i = 0; i < hold; i++)
                    step(!ch, ch, 1'b0);
                idle($urandom_range(1, 2));
            end else if (kind == 3) begin
                hold = $urandom_range(DB, DB + 3);
                for (int i = 0; i < hold; i++)
                    step(1'b1, 1'b1, 1'b0);
                idle($urandom_range(1, 5));
            end else begin
                hold = $urandom_range(DB, DB + 4);
                gap  = ($urandom_range(0, 3) == 0) ? $urandom_range(TO, TO + 10) : $urandom_range(1, 8);
                for (int i = 0; i < hold; i++)
                    step(!ch, ch, 1'b0);
                idle(gap);
            end
        end

        idle(3 * TO + 4 * DEPTH + 10);
        check("sb_codes_drained", code_sb.size(), 0);
        check("sb_rejects_drained", rej_sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/coin_feeder.md
# coin_feeder

Upstream coin-intake stage for the vending FSM. It converts raw coin-sensor levels into the 2-bit coin code the vending FSM samples every clock. It synchronises and debounces two sensor lines and queues accepted coins in a small FIFO. It then replays each transaction's coins as a back-to-back burst, one code per cycle, followed by idle code 00, so the FSM sees an unbroken coin sequence and then its change/cancel condition.

## Interface
- DEBOUNCE_CYCLES, 4, consecutive synchronised-high cycles needed to accept a coin (≥1)
- TIMEOUT, 16, idle cycles after the last accepted coin before a burst starts (≥2)
- DEPTH, 4, FIFO entries (power of two, ≥2)
- clk  in  1  rising-edge clock, the only clock
- rst  in  1  synchronous, active-high reset
- coin5_raw  in  1  asynchronous, bouncy sensor level for a 5-unit coin
- coin10_raw  in  1  asynchronous, bouncy sensor level for a 10-unit coin
- coin_code  out  2  registered code to the vending FSM `in` port: 00 none, 01 = 5, 10 = 10 (11 never driven)
- busy  out  1  high while in BURST
- reject  out  1  one-cycle pulse when a detected coin is discarded
- pending  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- Each sensor passes through a 2-flop synchroniser.
- **Debounce**
  - Each channel has a counter; a synchronised low clears it to 0.
  - A synchronised high increments the counter, saturating at DEBOUNCE_CYCLES.
  - A detect pulse fires in the cycle the counter first reaches DEBOUNCE_CYCLES, so there is one detect per stable high period.
  - Any low cycle re-arms the channel.
- **Accept rules**
  - Detect on both channels in the same cycle: both discarded, reject=1.
  - Single detect with the FIFO full at the push point: coin discarded, reject=1.
  - Otherwise push the code (01 or 10).
  - A push is allowed in the same cycle as a pop.
- **States**
  - IDLE: FIFO empty. A push moves to COLLECT and clears the idle counter.
  - COLLECT
    - Every push clears the idle counter; otherwise it increments.
    - Go to BURST when the idle counter reaches TIMEOUT, or when the FIFO becomes full.
    - On entry to BURST, latch burst_len = pending.
  - BURST
    - Pop one entry per cycle into coin_code for burst_len cycles.
    - Coins accepted during BURST are queued and are not part of the current burst.
    - After the last pop, coin_code=00 for at least one cycle.
    - Then go to COLLECT if pending>0 (idle counter cleared), else IDLE.
- coin_code is 00 in every cycle where no pop occurs.
- **Width rules**
  - Idle counter saturates at TIMEOUT.
  - pending never exceeds DEPTH.
  - Pointers wrap modulo DEPTH.

## Timing
- **Reset values:** coin_code=00, busy=0, reject=0, pending=0, state IDLE; synchroniser, debounce counters and FIFO pointers cleared.
- **rst mid-burst:** remaining coins are discarded, and coin_code is 00 in the cycle after rst is sampled.
- **Sensor to push:** a raw edge that is high from cycle 0 is pushed at cycle 2+DEBOUNCE_CYCLES (2 synchroniser cycles + debounce).
- **Last push to first code:** the idle counter reaches TIMEOUT TIMEOUT cycles after the push. BURST is entered the next cycle, and the first coin_code appears that cycle (registered pop).
- **Full-trigger:** BURST is entered the cycle after pending reaches DEPTH.
- busy rises with the first popped code and falls with the first trailing 00.
- reject is asserted in the detect cycle and lasts exactly 1 cycle.
- **Throughput:** one code per cycle within a burst; at least one 00 between bursts.

## Configuration
- Macro `COIN_FEEDER_STATS_EN`.
- **Defined:** adds output port `total_value`, 8 bits.
  - Reset to 0.
  - Adds 1 for each emitted 01 and 2 for each emitted 10.
  - Saturates at 255.
  - rst clears it.
- **Undefined:** port and logic absent; all other behaviour identical.

## Test plan
- **Single coin:** coin5_raw high 8 cycles, defaults → push at cycle 6; coin_code=01 for exactly 1 cycle at cycle 6+16+1=23, then 00; busy high only at cycle 23.
- **Two-coin burst:** 10-coin accepted, then a 5-coin 10 cycles later → after timeout, coin_code=10 then 01 on consecutive cycles, then 00; pending goes 2→1→0.
- **Bounce:** coin10_raw high 3, low 1, high 3, low → no push, no reject, coin_code stays 00.
- **Simultaneous:** both raw lines rise in the same cycle and are held 6 cycles → reject pulse at cycle 6; pending stays 0.
- **Overflow:**
  - Four coins accepted, then a fifth detect arrives in the cycle pending=4 before the first pop → reject=1.
  - Burst emits exactly the 4 queued codes.
- **Reset mid-burst:** rst for 1 cycle during the second code of a 3-coin burst → next cycle coin_code=00 and pending=0; a fresh coin afterwards is accepted normally. With STATS_EN, total_value is 0 after rst.
